// File: rtl/shift_reg_seq.sv
// shift_reg_seq: sequencer/arbiter sharing one universal shift register
// between a byte transmitter (parallel-in, serial-out) and a byte
// receiver (serial-in, parallel-out).
module shift_reg_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BIT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsb_first_i,
  input  logic             tx_valid_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             tx_ready_o,
  output logic             tx_done_o,
  input  logic             rx_start_i,
  input  logic             ser_i,
  output logic             rx_valid_o,
  output logic [WIDTH-1:0] rx_data_o,
  input  logic             rx_ready_i,
  output logic             ser_o,
  output logic             ser_en_o,
  output logic             busy_o,
  output logic [1:0]       sr_mode_o,
  output logic [WIDTH-1:0] sr_par_o,
  output logic             sr_d_o,
  input  logic [WIDTH-1:0] sr_p_i
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    TX_SHIFT = 3'd2,
    RX_SHIFT = 3'd3,
    RX_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q;
  logic [DW-1:0]   div_cnt_q;
  logic            dir_q;
  logic            last_grant_tx_q;
  logic [WIDTH-1:0] par_q;
  logic            tx_done_q;

  logic is_idle, shifting, shift_cyc, last_shift, tx_grant, rx_grant;

  // Arbitration and shift-timing decode; TX wins a tie unless it won last time.
  always_comb begin
    is_idle    = (state_q == IDLE);
    shifting   = (state_q == TX_SHIFT) || (state_q == RX_SHIFT);
    shift_cyc  = shifting && (div_cnt_q == DIV_LAST);
    last_shift = shift_cyc && (bit_cnt_q == BIT_LAST);
    tx_ready_o = is_idle && !rst && !(rx_start_i && last_grant_tx_q);
    tx_grant   = tx_ready_o && tx_valid_i;
    rx_grant   = is_idle && !rst && rx_start_i && !tx_grant;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tx_grant)      state_d = LOAD;
        else if (rx_grant) state_d = RX_SHIFT;
      end
      LOAD:     state_d = TX_SHIFT;
      TX_SHIFT: if (last_shift) state_d = IDLE;
      RX_SHIFT: if (last_shift) state_d = RX_DONE;
      RX_DONE:  if (rx_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, counters, grant bookkeeping and captured TX byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      div_cnt_q       <= '0;
      dir_q           <= 1'b0;
      last_grant_tx_q <= 1'b0;
      par_q           <= '0;
      tx_done_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_done_q <= (state_q == TX_SHIFT) && last_shift;
      if (tx_grant) begin
        par_q           <= tx_data_i;
        dir_q           <= lsb_first_i;
        last_grant_tx_q <= 1'b1;
      end else if (rx_grant) begin
        dir_q           <= lsb_first_i;
        last_grant_tx_q <= 1'b0;
      end
      // Counters sit at zero outside the shift states, so every shift
      // state is entered with both counters cleared.
      if (!shifting) begin
        div_cnt_q <= '0;
        bit_cnt_q <= '0;
      end else begin
        div_cnt_q <= shift_cyc ? '0 : div_cnt_q + DW'(1);
        if (shift_cyc) bit_cnt_q <= last_shift ? '0 : bit_cnt_q + BW'(1);
      end
    end
  end

  // Register control and user-facing outputs; all forced low during reset.
  always_comb begin
    sr_mode_o  = M_HOLD;
    sr_d_o     = 1'b0;
    sr_par_o   = '0;
    ser_o      = 1'b0;
    ser_en_o   = 1'b0;
    rx_valid_o = 1'b0;
    rx_data_o  = '0;
    busy_o     = 1'b0;
    tx_done_o  = 1'b0;
    if (!rst) begin
      busy_o    = !is_idle;
      tx_done_o = tx_done_q;
      sr_par_o  = par_q;
      case (state_q)
        LOAD: sr_mode_o = M_LOAD;
        TX_SHIFT: begin
          ser_en_o = 1'b1;
          ser_o    = dir_q ? sr_p_i[0] : sr_p_i[WIDTH-1];
          if (shift_cyc) sr_mode_o = dir_q ? M_RIGHT : M_LEFT;
        end
        RX_SHIFT: begin
          if (shift_cyc) begin
            sr_mode_o = dir_q ? M_RIGHT : M_LEFT;
            sr_d_o    = ser_i;
          end
        end
        RX_DONE: begin
          rx_valid_o = 1'b1;
          rx_data_o  = sr_p_i;
        end
        default: ;
      endcase
    end
  end

endmodule
